// File: rtl/hack_cpu_mc.sv
// Multicycle HACK CPU: FETCH/READ/EXEC/WRITE sequencer over ready-handshaked ROM and data ports.
// Define HACK_CPU_HALT_EN to detect the "@L; 0;JMP" end loop and park the core in HALT.
module hack_cpu_mc #(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic [PC_WIDTH-1:0] o_inst_addr,
    output logic                o_inst_req,
    input  logic                i_inst_rdy,
    input  logic [15:0]         i_inst_data,
    output logic [WIDTH-1:0]    o_mem_addr,
    output logic                o_mem_re,
    output logic                o_mem_we,
    output logic [WIDTH-1:0]    o_mem_wdata,
    input  logic [WIDTH-1:0]    i_mem_rdata,
    input  logic                i_mem_rdy,
    output logic                o_retire,
    output logic                o_halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_READ,
        S_EXEC,
        S_WRITE
`ifdef HACK_CPU_HALT_EN
        , S_HALT
`endif
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_d;
    logic [WIDTH-1:0]    r_m;
    // Only the C-instruction fields are kept; bits 15:13 are known to be 1 in EXEC.
    logic [12:0]         r_ir;
    logic [WIDTH-1:0]    r_mem_addr;
    logic [WIDTH-1:0]    r_wdata;
    logic                r_inst_req;
    logic                r_mem_re;
    logic                r_mem_we;
    logic                r_retire;

    logic [WIDTH-1:0]    w_alu_x;
    logic [WIDTH-1:0]    w_alu_y;
    logic [WIDTH-1:0]    w_alu_f;
    logic [WIDTH-1:0]    w_alu_out;
    logic                w_zr;
    logic                w_ng;
    logic                w_jump;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0]    w_a_imm;
    logic [WIDTH-1:0]    w_a_exec;

    always_comb begin
        w_alu_x = r_ir[11] ? '0 : r_d;
        if (r_ir[10]) w_alu_x = ~w_alu_x;
        w_alu_y = r_ir[12] ? r_m : r_a;
        if (r_ir[9]) w_alu_y = '0;
        if (r_ir[8]) w_alu_y = ~w_alu_y;
        w_alu_f   = r_ir[7] ? (w_alu_x + w_alu_y) : (w_alu_x & w_alu_y);
        w_alu_out = r_ir[6] ? ~w_alu_f : w_alu_f;
    end

    assign w_zr      = (w_alu_out == '0);
    assign w_ng      = w_alu_out[WIDTH-1];
    assign w_jump    = (r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_ng & ~w_zr);
    assign w_pc_inc  = r_pc + PC_WIDTH'(1);
    // Jump target is the A value from before this instruction's own A update.
    assign w_pc_next = w_jump ? r_a[PC_WIDTH-1:0] : w_pc_inc;
    assign w_a_imm   = {{(WIDTH-15){1'b0}}, i_inst_data[14:0]};
    assign w_a_exec  = r_ir[5] ? w_alu_out : r_a;

`ifdef HACK_CPU_HALT_EN
    logic r_prev_a;
    logic r_halted;
    logic w_halt;

    assign w_halt = r_prev_a && (r_ir[2:0] == 3'b111) && (r_ir[5:3] == 3'b000)
                    && (r_a[PC_WIDTH-1:0] == (r_pc - PC_WIDTH'(1)));
    assign o_halted = r_halted;
`else
    assign o_halted = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_a        <= '0;
            r_d        <= '0;
            r_m        <= '0;
            r_ir       <= '0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_inst_req <= 1'b1;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_retire   <= 1'b0;
`ifdef HACK_CPU_HALT_EN
            r_prev_a   <= 1'b0;
            r_halted   <= 1'b0;
`endif
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (i_inst_rdy) begin
                        r_ir <= i_inst_data[12:0];
                        if (!i_inst_data[15]) begin
                            r_a        <= w_a_imm;
                            r_mem_addr <= w_a_imm;
                            r_pc       <= w_pc_inc;
                            r_retire   <= 1'b1;
`ifdef HACK_CPU_HALT_EN
                            r_prev_a   <= 1'b1;
`endif
                        end else begin
                            r_inst_req <= 1'b0;
                            if (i_inst_data[12]) begin
                                r_mem_re <= 1'b1;
                                r_state  <= S_READ;
                            end else begin
                                r_state  <= S_EXEC;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (i_mem_rdy) begin
                        r_m      <= i_mem_rdata;
                        r_mem_re <= 1'b0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_ir[5]) r_a <= w_alu_out;
                    if (r_ir[4]) r_d <= w_alu_out;
                    r_pc <= w_pc_next;
                    if (r_ir[3]) begin
                        r_wdata    <= w_alu_out;
                        r_mem_addr <= r_a;
                        r_mem_we   <= 1'b1;
                        r_state    <= S_WRITE;
                    end
`ifdef HACK_CPU_HALT_EN
                    else if (w_halt) begin
                        r_retire   <= 1'b1;
                        r_halted   <= 1'b1;
                        r_prev_a   <= 1'b0;
                        r_mem_addr <= w_a_exec;
                        r_state    <= S_HALT;
                    end
`endif
                    else begin
                        r_retire   <= 1'b1;
                        r_inst_req <= 1'b1;
                        r_mem_addr <= w_a_exec;
                        r_state    <= S_FETCH;
`ifdef HACK_CPU_HALT_EN
                        r_prev_a   <= 1'b0;
`endif
                    end
                end
                S_WRITE: begin
                    if (i_mem_rdy) begin
                        r_mem_we   <= 1'b0;
                        r_retire   <= 1'b1;
                        r_inst_req <= 1'b1;
                        r_mem_addr <= r_a;
                        r_state    <= S_FETCH;
`ifdef HACK_CPU_HALT_EN
                        r_prev_a   <= 1'b0;
`endif
                    end
                end
`ifdef HACK_CPU_HALT_EN
                S_HALT: begin
                    r_state <= S_HALT;
                end
`endif
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign o_inst_addr = r_pc;
    assign o_inst_req  = r_inst_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_re    = r_mem_re;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_wdata;
    assign o_retire    = r_retire;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Randomized bench for hack_cpu_mc: an instruction-level HACK model checks every retire,
// while a wait-state ROM/RAM environment serves the handshaked ports.
module tb_hack_cpu_mc;
    localparam int WIDTH    = 16;
    localparam int PC_WIDTH = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic [PC_WIDTH-1:0] o_inst_addr;
    logic                o_inst_req;
    logic                i_inst_rdy;
    logic [15:0]         i_inst_data;
    logic [WIDTH-1:0]    o_mem_addr;
    logic                o_mem_re;
    logic                o_mem_we;
    logic [WIDTH-1:0]    o_mem_wdata;
    logic [WIDTH-1:0]    i_mem_rdata;
    logic                i_mem_rdy;
    logic                o_retire;
    logic                o_halted;

    always #5 clk = ~clk;

    hack_cpu_mc #(.WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .o_inst_addr(o_inst_addr),
        .o_inst_req (o_inst_req),
        .i_inst_rdy (i_inst_rdy),
        .i_inst_data(i_inst_data),
        .o_mem_addr (o_mem_addr),
        .o_mem_re   (o_mem_re),
        .o_mem_we   (o_mem_we),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_rdy  (i_mem_rdy),
        .o_retire   (o_retire),
        .o_halted   (o_halted)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] rom   [int];
    logic [15:0] e_ram [int];
    logic [15:0] m_ram [int];

    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    bit          m_prev_a, m_halted;

    int cyc, waits, retired, we_cycles;
    int iw_cnt, iw_tgt, mw_cnt, mw_tgt, inst_fix, mem_fix;
    bit rand_mode;
    int rq[$];
    int wq_a[$];
    int wq_d[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rom_rd(input int addr);
        return rom.exists(addr) ? rom[addr] : 16'h0000;
    endfunction

    function automatic logic [15:0] eram_rd(input int addr);
        return e_ram.exists(addr) ? e_ram[addr] : 16'h0000;
    endfunction

    function automatic logic [15:0] mram_rd(input int addr);
        return m_ram.exists(addr) ? m_ram[addr] : 16'h0000;
    endfunction

    // ALU expressed arithmetically on 0..65535: bitwise NOT is 65535 - v.
    function automatic logic [15:0] ref_alu(input logic [15:0] x0, input logic [15:0] y0, input logic [5:0] c);
        int x, y, r;
        x = c[5] ? 0 : int'(x0);
        if (c[4]) x = 65535 - x;
        y = c[3] ? 0 : int'(y0);
        if (c[2]) y = 65535 - y;
        r = c[1] ? ((x + y) % 65536) : (x & y);
        if (c[0]) r = 65535 - r;
        return r[15:0];
    endfunction

    task automatic model_step(output bit e_re, output int e_raddr, output bit e_we,
                              output int e_waddr, output int e_wdata, output int e_min);
        logic [15:0] ins, y, o;
        bit zr, ng, tk;
        ins = rom_rd(int'(m_pc));
        e_re = 0; e_raddr = 0; e_we = 0; e_waddr = 0; e_wdata = 0;
        if (!ins[15]) begin
            m_a      = {1'b0, ins[14:0]};
            m_pc     = m_pc + 15'd1;
            m_prev_a = 1;
            e_min    = 1;
        end else begin
            if (ins[12]) begin
                y = mram_rd(int'(m_a));
                e_re = 1; e_raddr = int'(m_a);
            end else begin
                y = m_a;
            end
            o  = ref_alu(m_d, y, ins[11:6]);
            ng = o[15];
            zr = (o == 16'h0000);
            tk = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr);
`ifdef HACK_CPU_HALT_EN
            if (m_prev_a && ins[2:0] == 3'b111 && ins[5:3] == 3'b000 && m_a[14:0] == m_pc - 15'd1)
                m_halted = 1;
`endif
            if (ins[3]) begin
                m_ram[int'(m_a)] = o;
                e_we = 1; e_waddr = int'(m_a); e_wdata = int'(o);
            end
            m_pc = tk ? m_a[14:0] : m_pc + 15'd1;
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
            e_min    = 2 + int'(ins[12]) + int'(ins[3]);
            m_prev_a = 0;
        end
    endtask

    task automatic on_retire();
        bit e_re, e_we;
        int e_raddr, e_waddr, e_wdata, e_min;
        if (m_halted) begin
            chk("retire_after_halt", 32'(o_retire), 32'd0);
            return;
        end
        model_step(e_re, e_raddr, e_we, e_waddr, e_wdata, e_min);
        retired++;
        chk("latency", 32'(cyc), 32'(e_min + waits));
        cyc = 0;
        waits = 0;
        if (e_re) begin
            if (rq.size() == 0) chk("read_missing", 32'd0, 32'd1);
            else chk("read_addr", 32'(rq.pop_front()), 32'(e_raddr));
        end
        chk("read_extra", 32'(rq.size()), 32'd0);
        if (e_we) begin
            if (wq_a.size() == 0) chk("write_missing", 32'd0, 32'd1);
            else begin
                chk("write_addr", 32'(wq_a.pop_front()), 32'(e_waddr));
                chk("write_data", 32'(wq_d.pop_front()), 32'(e_wdata));
            end
        end
        chk("write_extra", 32'(wq_a.size()), 32'd0);
        chk("halted", 32'(o_halted), 32'(m_halted));
        if (!m_halted) chk("pc", 32'(o_inst_addr), 32'(m_pc));
        chk("a_reg", 32'(o_mem_addr), 32'(m_a));
    endtask

    function automatic int new_wait(input int fix);
        if (rand_mode) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        return fix;
    endfunction

    task automatic drive();
        if (o_inst_req) begin
            if (iw_cnt >= iw_tgt) begin
                i_inst_rdy  = 1'b1;
                i_inst_data = rom_rd(int'(o_inst_addr));
                iw_cnt = 0;
                iw_tgt = new_wait(inst_fix);
            end else begin
                i_inst_rdy  = 1'b0;
                i_inst_data = 16'($urandom);
                iw_cnt++;
                waits++;
            end
        end else begin
            i_inst_rdy  = 1'($urandom);
            i_inst_data = 16'($urandom);
        end
        if (o_mem_re || o_mem_we) begin
            if (mw_cnt >= mw_tgt) begin
                i_mem_rdy = 1'b1;
                if (o_mem_re) begin
                    rq.push_back(int'(o_mem_addr));
                    i_mem_rdata = eram_rd(int'(o_mem_addr));
                end else begin
                    e_ram[int'(o_mem_addr)] = o_mem_wdata;
                    wq_a.push_back(int'(o_mem_addr));
                    wq_d.push_back(int'(o_mem_wdata));
                    i_mem_rdata = 16'($urandom);
                end
                mw_cnt = 0;
                mw_tgt = new_wait(mem_fix);
            end else begin
                i_mem_rdy   = 1'b0;
                i_mem_rdata = 16'($urandom);
                mw_cnt++;
                waits++;
            end
        end else begin
            i_mem_rdy   = 1'($urandom);
            i_mem_rdata = 16'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (o_mem_we) we_cycles++;
        if (o_retire) on_retire();
        drive();
    endtask

    task automatic run_instrs(input int n, input int budget);
        int target, k;
        target = retired + n;
        k = 0;
        while (retired < target && k < budget) begin
            tick();
            k++;
        end
        if (retired < target) chk("timeout_retires", 32'(retired), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_inst_rdy = 1'b0;
        i_mem_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        m_a = 0; m_d = 0; m_pc = 0; m_prev_a = 0; m_halted = 0;
        rq.delete(); wq_a.delete(); wq_d.delete();
        iw_cnt = 0; mw_cnt = 0;
        iw_tgt = new_wait(inst_fix);
        mw_tgt = new_wait(mem_fix);
        cyc = 0; waits = 0;
        rst = 1'b0;
        drive();
    endtask

    task automatic clear_mem();
        rom.delete();
        e_ram.delete();
        m_ram.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_inst_rdy = 1'b0; i_inst_data = '0; i_mem_rdata = '0; i_mem_rdy = 1'b0;
        rand_mode = 0; inst_fix = 0; mem_fix = 0; retired = 0; we_cycles = 0;
        repeat (2) @(negedge clk);
        chk("rst_inst_addr", 32'(o_inst_addr), 32'd0);
        chk("rst_inst_req",  32'(o_inst_req),  32'd1);
        chk("rst_mem_re",    32'(o_mem_re),    32'd0);
        chk("rst_mem_we",    32'(o_mem_we),    32'd0);
        chk("rst_mem_addr",  32'(o_mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
        chk("rst_retire",    32'(o_retire),    32'd0);
        chk("rst_halted",    32'(o_halted),    32'd0);

        // @5; D=A; M=D+1 with a three-cycle write stall
        clear_mem();
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'hE7C8;
        mem_fix = 3;
        do_reset();
        run_instrs(1, 10);
        chk("ainst_a",   32'(o_mem_addr),  32'd5);
        chk("ainst_pc",  32'(o_inst_addr), 32'd1);
        chk("ainst_req", 32'(o_inst_req),  32'd1);
        we_cycles = 0;
        run_instrs(2, 30);
        chk("stall_we_cycles", 32'(we_cycles), 32'd4);
        chk("stall_ram5", 32'(eram_rd(5)), 32'd6);

        // @7; AM=M+1 with M[7]=9
        clear_mem();
        rom[0] = 16'h0007; rom[1] = 16'hFDE8;
        e_ram[7] = 16'd9; m_ram[7] = 16'd9;
        mem_fix = 0;
        do_reset();
        run_instrs(2, 20);
        chk("amm_ram7", 32'(eram_rd(7)), 32'd10);
        chk("amm_a",    32'(o_mem_addr), 32'd10);

        // conditional jumps on negative and zero D
        clear_mem();
        rom[0] = 16'hEE90; rom[1] = 16'hE301; rom[2] = 16'h0014; rom[3] = 16'hE304;
        rom[20] = 16'hEA90; rom[21] = 16'hE301; rom[22] = 16'hE302;
        inst_fix = 1;
        do_reset();
        run_instrs(7, 60);
        chk("jmp_final_pc", 32'(o_inst_addr), 32'd20);

        // PC wraps from 2^PC_WIDTH-1 to 0
        clear_mem();
        rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'hEA90;
        inst_fix = 0;
        do_reset();
        run_instrs(3, 20);
        chk("wrap_pc", 32'(o_inst_addr), 32'd0);

        // end loop @3; 0;JMP at addresses 3/4
        clear_mem();
        rom[0] = 16'h0003; rom[1] = 16'hEA87; rom[3] = 16'h0003; rom[4] = 16'hEA87;
        do_reset();
        run_instrs(4, 30);
`ifdef HACK_CPU_HALT_EN
        chk("halt_flag", 32'(o_halted), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_no_req", 32'(o_inst_req), 32'd0);
            chk("halt_no_mem", 32'(o_mem_re | o_mem_we), 32'd0);
            chk("halt_hold",   32'(o_halted), 32'd1);
        end
`else
        run_instrs(4, 30);
        chk("loop_pc", 32'(o_inst_addr), 32'd3);
        chk("loop_no_halt", 32'(o_halted), 32'd0);
`endif

        // reset while a write is stalled
        clear_mem();
        rom[0] = 16'h0005; rom[1] = 16'hE7C8;
        mem_fix = 1000;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_mem_we) break;
        end
        chk("abort_saw_we", 32'(o_mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_we",   32'(o_mem_we),    32'd0);
        chk("abort_pc",   32'(o_inst_addr), 32'd0);
        chk("abort_req",  32'(o_inst_req),  32'd1);
        mem_fix = 0;
        do_reset();
        chk("abort_restart_pc", 32'(o_inst_addr), 32'd0);
        chk("abort_no_write",   32'(e_ram.exists(5)), 32'd0);
        run_instrs(2, 20);
        chk("abort_redo_write", 32'(eram_rd(5)), 32'd1);

        // randomized programs and wait states
        for (int r = 0; r < 3; r++) begin
            clear_mem();
            for (int i = 0; i < 64; i++) begin
                logic [15:0] w, v;
                logic [2:0]  d, j;
                if ($urandom_range(0, 2) == 0) begin
                    w = 16'($urandom_range(0, 63));
                end else begin
                    d = 3'($urandom);
                    j = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
                    if (j == 3'b111 && d == 3'b000) d = 3'b010;
                    w = {3'b111, 1'($urandom), 6'($urandom), d, j};
                end
                rom[i] = w;
                v = 16'($urandom);
                e_ram[i] = v;
                m_ram[i] = v;
            end
            rand_mode = 1;
            do_reset();
            run_instrs(300, 300 * 12);
            rand_mode = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
